sequenciador_mul_ula: RTL and testbench
=======================================

Name: sequenciador_mul_ula

Overview:
Multi-cycle shift-and-add multiplier controller that time-shares the existing ULA adder/subtractor instead of instantiating a dedicated multiplier. It captures two operands on a start request and drives the ULA control and data inputs for one add-step per cycle. It accumulates the result from ULA dout and returns the low BITS of the product with a done pulse. It sits beside the ULA in the DataFlow and takes ownership of the ULA inputs while busy; the ULA mux in the DataFlow selects these outputs when ocupado=1.

Parameters:
BITS, 64, operand/result width; must match the ULA's BITS.
CNT_W, $clog2(BITS)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in OCIOSO.
multiplicando  input  BITS  operand A; captured when start is accepted.
multiplicador  input  BITS  operand B; captured when start is accepted.
ocupado  output  1  high from the cycle after acceptance through FIM.
done  output  1  one-cycle pulse in FIM.
produto  output  BITS  low BITS of A*B; held until the next acceptance.
ula_dina  output  BITS  to ULA dina.
ula_dinb  output  BITS  to ULA dinb.
ula_constante  output  BITS  to ULA constante; always 0.
ula_soma_ou_subtrai  output  1  to ULA; 1 only in CALC.
ula_subtraindo  output  1  to ULA; always 0.
ula_imediato  output  1  to ULA; always 0.
ula_dout  input  BITS  from ULA dout (combinational, same cycle).

Behaviour:
- Reset (synchronous, active-high): state=OCIOSO; acc, mcand, mplier, cnt, produto = 0; done=0; ocupado=0. Reset mid-operation aborts the multiply with no done pulse. Reset has priority over start.
- States: OCIOSO, CALC, FIM.
- OCIOSO:
  - ULA outputs all 0, so ULA dout = 0.
  - If start=1: mcand<=multiplicando, mplier<=multiplicador, acc<=0, cnt<=0, go to CALC.
- CALC:
  - Drive ula_dina=acc, ula_dinb=mcand, ula_soma_ou_subtrai=1, ula_subtraindo=0, ula_imediato=0.
  - If mplier[0]=1, acc<=ula_dout; otherwise acc holds.
  - mcand<=mcand<<1 (bits shifted past BITS are discarded); mplier<=mplier>>1 (logical); cnt<=cnt+1.
  - Exit to FIM when cnt==BITS-1 (exactly BITS CALC cycles).
- FIM:
  - produto<=acc; done=1 for this cycle only; go to OCIOSO.
  - produto is visible the cycle after FIM and held until the next FIM.
- Latency: start sampled at edge 0; CALC occupies edges 1..BITS; done high in the cycle following edge BITS; produto valid from edge BITS+1. Next start accepted at the earliest in the cycle after FIM.
- ocupado = (state != OCIOSO).
- start while ocupado=1 is ignored; no queueing.
- Arithmetic: modulo 2^BITS. Low BITS are correct for both unsigned and two's-complement operands; no high half, no overflow flag.
- Operand inputs may change freely after acceptance; internal copies are used.

Optional Feature:
MUL_SAIDA_ANTECIPADA_EN
- Defined: CALC also exits to FIM when (mplier>>1)==0 after the current step. Iteration count = index of the highest set bit of multiplicador + 1, minimum 1; multiplicador=0 takes 1 CALC cycle.
- Not defined: a fixed BITS CALC cycles regardless of operands.
- Result values are identical in both builds.

Decomposition:
- Shared package ula_pkg: state enum (OCIOSO, CALC, FIM) and a helper CNT_W function. BITS stays a module parameter, consistent with the ULA.
- No sub-module: the datapath is the external ULA, and the control FSM plus operand registers fit in one module.

Test Plan:
- BITS=64, A=7, B=6, start for 1 cycle → ocupado for 64 CALC cycles plus FIM; done single pulse; produto=42; ula_soma_ou_subtrai=1 only during CALC.
- A=0xFFFF_FFFF_FFFF_FFFF, B=2 → produto=0xFFFF_FFFF_FFFF_FFFE (wrap); A=-3 (two's complement), B=5 → produto=-15.
- start re-asserted with A=9, B=9 during CALC → ignored; first result returned unchanged; a new start after done yields 81.
- reset asserted at CALC cycle 10 → next cycle: OCIOSO, ocupado=0, produto=0, no done pulse; a subsequent start with A=3, B=4 → 12.
- With MUL_SAIDA_ANTECIPADA_EN: B=0 → done 2 cycles after acceptance, produto=0; B=0x80 → 8 CALC cycles, A=3 → produto=0x180. Without the macro, both cases take 64 CALC cycles with the same results.
- Idle check: in OCIOSO, ula_dina, ula_dinb, ula_constante and all ULA controls are 0; back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared ULA definitions: multiply sequencer states and width helper.
// Imported by sequenciador_mul_ula; BITS remains a module parameter.
package ula_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    function automatic int cnt_w(input int bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/sequenciador_mul_ula.sv
// Shift-and-add multiply sequencer that borrows the external ULA adder.
// Ports: clk/reset (sync, active-high); start + multiplicando/multiplicador
// request; ocupado/done/produto status and result; ula_* drive the shared
// ULA inputs while busy, ula_dout is the ULA sum fed back the same cycle.
// Optional MUL_SAIDA_ANTECIPADA_EN: leave CALC once no multiplier bits remain.
module sequenciador_mul_ula
    import ula_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] multiplicando,
    input  logic [BITS-1:0] multiplicador,
    output logic            ocupado,
    output logic            done,
    output logic [BITS-1:0] produto,
    output logic [BITS-1:0] ula_dina,
    output logic [BITS-1:0] ula_dinb,
    output logic [BITS-1:0] ula_constante,
    output logic            ula_soma_ou_subtrai,
    output logic            ula_subtraindo,
    output logic            ula_imediato,
    input  logic [BITS-1:0] ula_dout
);

    localparam int CNT_W = cnt_w(BITS);

    estado_t          r_estado;
    estado_t          w_prox;
    logic [BITS-1:0]  r_acc;
    logic [BITS-1:0]  r_mcand;
    logic [BITS-1:0]  r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [BITS-1:0]  r_produto;
    logic             w_ultimo;

`ifdef MUL_SAIDA_ANTECIPADA_EN
    // Remaining multiplier bits all zero: further steps cannot change acc.
    assign w_ultimo = (r_cnt == CNT_W'(BITS - 1)) ||
                      ((r_mplier >> 1) == '0);
`else
    assign w_ultimo = (r_cnt == CNT_W'(BITS - 1));
`endif

    assign ocupado        = (r_estado != OCIOSO);
    assign produto        = r_produto;
    assign ula_constante  = '0;
    assign ula_subtraindo = 1'b0;
    assign ula_imediato   = 1'b0;

    always_comb begin
        w_prox              = r_estado;
        done                = 1'b0;
        ula_dina            = '0;
        ula_dinb            = '0;
        ula_soma_ou_subtrai = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (start) w_prox = CALC;
            end
            CALC: begin
                ula_dina            = r_acc;
                ula_dinb            = r_mcand;
                ula_soma_ou_subtrai = 1'b1;
                if (w_ultimo) w_prox = FIM;
            end
            FIM: begin
                done   = 1'b1;
                w_prox = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_produto <= '0;
        end else begin
            r_estado <= w_prox;
            unique case (r_estado)
                OCIOSO: begin
                    if (start) begin
                        r_mcand  <= multiplicando;
                        r_mplier <= multiplicador;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    // ULA computes acc + mcand; keep it only for a set bit.
                    if (r_mplier[0]) r_acc <= ula_dout;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                FIM: begin
                    r_produto <= r_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_mul_ula.sv
// Bench for sequenciador_mul_ula: cycle model plus directed products.
// Works with or without MUL_SAIDA_ANTECIPADA_EN defined.
module tb_sequenciador_mul_ula;

    localparam int W = 64;
`ifdef MUL_SAIDA_ANTECIPADA_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int FULL_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] multiplicando;
    logic [W-1:0] multiplicador;
    logic         ocupado;
    logic         done;
    logic [W-1:0] produto;
    logic [W-1:0] ula_dina;
    logic [W-1:0] ula_dinb;
    logic [W-1:0] ula_constante;
    logic         ula_soma_ou_subtrai;
    logic         ula_subtraindo;
    logic         ula_imediato;
    logic [W-1:0] ula_dout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Simple combinational ULA stand-in.
    assign ula_dout = !ula_soma_ou_subtrai ? '0 :
                      ula_subtraindo ? ula_dina - ula_dinb :
                      ula_dina + ula_dinb + ula_constante;

    sequenciador_mul_ula #(.BITS(W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .multiplicando       (multiplicando),
        .multiplicador       (multiplicador),
        .ocupado             (ocupado),
        .done                (done),
        .produto             (produto),
        .ula_dina            (ula_dina),
        .ula_dinb            (ula_dinb),
        .ula_constante       (ula_constante),
        .ula_soma_ou_subtrai (ula_soma_ou_subtrai),
        .ula_subtraindo      (ula_subtraindo),
        .ula_imediato        (ula_imediato),
        .ula_dout            (ula_dout)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Number of add steps the sequencer must spend on multiplier b.
    function automatic int steps(input logic [W-1:0] b);
        int n;
        if (!EARLY) return W;
        n = 1;
        for (int k = 0; k < W; k++)
            if (b[k]) n = k + 1;
        return n;
    endfunction

    // Model: remaining busy cycles after acceptance (steps + final cycle).
    int           m_left = 0;
    int           m_n = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_prod = '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_a    = multiplicando;
                m_b    = multiplicador;
                m_n    = steps(multiplicador);
                m_left = m_n + 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_prod = m_a * m_b;
        end
    end

    always @(negedge clk) begin
        int           i;
        logic [W-1:0] mask;
        chk("ocupado", W'(ocupado), W'(m_left > 0));
        chk("done", W'(done), W'(m_left == 1));
        chk("soma", W'(ula_soma_ou_subtrai), W'(m_left > 1));
        chk("produto", produto, m_prod);
        chk("constante", ula_constante, '0);
        chk("subtraindo", W'(ula_subtraindo), '0);
        chk("imediato", W'(ula_imediato), '0);
        if (m_left > 1) begin
            i    = m_n + 1 - m_left;
            mask = (W'(1) << i) - W'(1);
            chk("dina_calc", ula_dina, m_a * (m_b & mask));
            chk("dinb_calc", ula_dinb, m_a << i);
        end else if (m_left == 0) begin
            chk("dina_idle", ula_dina, '0);
            chk("dinb_idle", ula_dinb, '0);
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", W'(done), W'(1));
    endtask

    // Issue one multiply at a negedge; return after produto is visible.
    task automatic mul(input string nm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp,
                       input int lat_early);
        int lat;
        start         = 1'b1;
        multiplicando = a;
        multiplicador = b;
        @(negedge clk);
        start         = 1'b0;
        multiplicando = ~a;
        multiplicador = ~b;
        wait_done(lat);
        chk({nm, "_lat"}, W'(lat + 1), W'(EARLY ? lat_early : FULL_LAT));
        @(negedge clk);
        chk({nm, "_prod"}, produto, exp);
    endtask

    initial begin
        int lat;
        reset         = 1'b1;
        start         = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ocupado", W'(ocupado), '0);
        chk("rst_produto", produto, '0);
        chk("rst_done", W'(done), '0);

        mul("m7x6", 64'd7, 64'd6, 64'd42, 4);
        mul("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFE, 3);
        mul("neg", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
            64'hFFFF_FFFF_FFFF_FFF1, 4);

        // Start pulses while busy must be ignored.
        start         = 1'b1;
        multiplicando = 64'd7;
        multiplicador = 64'h8000_0000_0000_0006;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start         = 1'b1;
        multiplicando = 64'd9;
        multiplicador = 64'd9;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        @(negedge clk);
        chk("ignore_prod", produto, 64'h8000_0000_0000_002A);
        mul("m9x9", 64'd9, 64'd9, 64'd81, 5);

        // Synchronous reset in the middle of CALC.
        start         = 1'b1;
        multiplicando = 64'd7;
        multiplicador = 64'h8000_0000_0000_0006;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_ocupado", W'(ocupado), W'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ocupado", W'(ocupado), '0);
        chk("abort_produto", produto, '0);
        repeat (4) @(negedge clk);
        chk("abort_done", W'(done), '0);
        mul("m3x4", 64'd3, 64'd4, 64'd12, 4);

        mul("bzero", 64'd5, 64'd0, 64'd0, 2);
        mul("b80", 64'd3, 64'h80, 64'h180, 9);

        repeat (2) @(negedge clk);
        chk("idle_dina", ula_dina, '0);
        chk("idle_ctrl", W'(ula_soma_ou_subtrai), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
